snake_tile_renderer: RTL and testbench
======================================

# snake_tile_renderer

Parametrised VGA renderer for the snake game. It replaces the per-pixel all-segment comparator with a per-scanline occupancy mask built sequentially during horizontal blanking. It contains its own 640x480@60 timing generator and snapshots game state once per frame, so each frame is tear-free. It sits between the game-logic core (food, snake arrays, length, game_state) and the board VGA pins.

## Interface
Parameters:
- GRID_W, 32: tile columns.
- GRID_H, 24: tile rows.
- TILE, 20: tile edge in pixels. GRID_W*TILE ≤ 640 and GRID_H*TILE ≤ 480.
- COORD_W, 5: coordinate width. 2^COORD_W ≥ max(GRID_W, GRID_H).
- MAX_LEN, 64: segment capacity. Must be ≤ 150.
- LEN_W, 7: width of snake_length. 2^LEN_W > MAX_LEN.
- BG_COLOR 12'h000, FOOD_COLOR 12'hfff, BODY_COLOR 12'hf00, HEAD_COLOR 12'hff0, DIE_COLOR 12'h444, INIT_COLOR 12'h00f, BORDER_COLOR 12'h222: RGB444 colours, {r,g,b}.

Ports:
- clk, in, 1: 25 MHz pixel clock.
- rst, in, 1: synchronous, active-high reset.
- food_x, food_y, in, COORD_W: food tile.
- snake_x_1dim, snake_y_1dim, in, MAX_LEN*COORD_W: segment k is at bits [k*COORD_W +: COORD_W]. Segment 0 is the head.
- snake_length, in, LEN_W: number of valid segments.
- game_state, in, 2: 00 RUNNING, 01 DIE, 10 INITIAL, 11 BLANK.
- r, g, b, out, 4 each: pixel colour.
- h_sync, v_sync, out, 1 each: active-low syncs.
- frame_tick, out, 1: one-cycle pulse at each snapshot.

## Operation
- **Counters**
  - hcnt counts 0..799. Visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
  - vcnt counts 0..524. Visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
  - Tile position is tracked with tile/sub-tile counters beside hcnt and vcnt. No divider is used.
- **Snapshot**
  - At hcnt=0, vcnt=480, latch food, both snake arrays, game_state and min(snake_length, MAX_LEN). Pulse frame_tick in the same cycle.
  - Inputs are ignored at all other times.
- **Mask build**
  - Each line L has a target tile row T, the tile row of the next displayed line.
  - During hcnt=640..640+MAX_LEN-1, step k=hcnt-640 examines snapshot segment k.
  - If k < len and y[k] = T and x[k] < GRID_W:
    - k=0: set head_mask[x[k]].
    - k>0: set body_mask[x[k]].
  - Food comparison runs once per line. It sets food_mask[food_x] if food_y = T and food_x < GRID_W.
  - At hcnt=799 the build masks copy to the active masks and the build masks clear.
  - The line after 524 is line 0, so its masks are built during line 524.
- **Pixel select**, for visible pixels only:
  - Pixel outside GRID_W*TILE x GRID_H*TILE: BORDER_COLOR.
  - INITIAL: INIT_COLOR everywhere inside the grid.
  - BLANK: 12'h000.
  - RUNNING, priority order: head > body > food > background (HEAD / BODY / FOOD / BG_COLOR).
  - DIE: head or body → DIE_COLOR; food → FOOD_COLOR; else BG.
  - Blanking region: rgb = 0.
- Coordinates ≥ GRID_W or ≥ GRID_H are never drawn.
- Overlapping segments are idempotent.
- Length 0 draws no snake.

## Timing
- r, g, b, h_sync and v_sync are registered. All are valid one cycle after the hcnt/vcnt values they represent, and are mutually aligned.
  - h_sync is low for exactly 96 clocks per line.
  - v_sync is low for exactly 2 lines (1600 clocks).
  - Line period is 800 clocks. Frame period is 420000 clocks.
- An input change becomes visible starting at the next frame's line 0, i.e. a latency of up to one frame plus 45 lines.
- Reset values:
  - hcnt = 0, vcnt = 0, all masks 0.
  - Snapshot: length 0, state INITIAL.
  - r = g = b = 0, h_sync = 1, v_sync = 1, frame_tick = 0.
- Reset asserted mid-frame restarts timing at 0,0 on the next cycle. The snapshot retains reset values until the first vcnt=480.

## Test plan
- **Reset and sync timing**
  - Stimulus: hold rst 3 cycles, then release.
  - Required: outputs at reset values.
  - Required: first h_sync fall 657 cycles after release, low 96 clocks, period 800.
  - Required: v_sync low lines 490-491. frame_tick period 420000.
- **Single segment**
  - Stimulus: RUNNING, length 1, head (3,2), food (10,10).
  - Required: pixels x 60-79, y 40-59 show ff0.
  - Required: pixels x 200-219, y 200-219 show fff. All others inside the grid show 000.
- **Priority**
  - Stimulus: head, a body segment and food all on tile (5,5).
  - Required: head colour on that tile.
  - Stimulus: remove the head from (5,5).
  - Required: body colour f00 on that tile.
- **Frame coherence**
  - Stimulus: change snake_x_1dim at vcnt=100.
  - Required: frame remains unchanged through line 479. The new position appears in the next frame.
- **Limits**
  - Stimulus: snake_length=127 with MAX_LEN=64.
  - Required: exactly 64 segments drawn.
  - Stimulus: segment x=31, and separately y=30 (GRID_H=24).
  - Required: x=31 drawn at the right edge; y=30 never drawn.
- **States**
  - Stimulus: DIE state.
  - Required: snake tiles 444, food fff.
  - Stimulus: INITIAL state.
  - Required: grid 00f.
  - Stimulus: BLANK state.
  - Required: rgb 0 with syncs still toggling.
  - Stimulus: assert rst mid-line.
  - Required: counters restart at 0.

Source files
------------

// File: rtl/snake_tile_renderer.sv
// snake_tile_renderer: 640x480 VGA renderer drawing the snake board from per-scanline tile masks
module snake_tile_renderer #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 24,
  parameter int TILE = 20,
  parameter int COORD_W = 5,
  parameter int MAX_LEN = 64,
  parameter int LEN_W = 7,
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter logic [11:0] FOOD_COLOR = 12'hfff,
  parameter logic [11:0] BODY_COLOR = 12'hf00,
  parameter logic [11:0] HEAD_COLOR = 12'hff0,
  parameter logic [11:0] DIE_COLOR = 12'h444,
  parameter logic [11:0] INIT_COLOR = 12'h00f,
  parameter logic [11:0] BORDER_COLOR = 12'h222
) (
  input  logic clk,
  input  logic rst,
  input  logic [COORD_W-1:0] food_x,
  input  logic [COORD_W-1:0] food_y,
  input  logic [MAX_LEN*COORD_W-1:0] snake_x_1dim,
  input  logic [MAX_LEN*COORD_W-1:0] snake_y_1dim,
  input  logic [LEN_W-1:0] snake_length,
  input  logic [1:0] game_state,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic h_sync,
  output logic v_sync,
  output logic frame_tick
);
  localparam int KW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam logic [1:0] RUNNING = 2'b00, INITIAL = 2'b10, BLANK = 2'b11;
  logic [9:0] hcnt, vcnt, col, hsub, row, vsub, k, tgt;
  logic [KW-1:0] ki;
  logic [COORD_W-1:0] sn_x [MAX_LEN];
  logic [COORD_W-1:0] sn_y [MAX_LEN];
  logic [COORD_W-1:0] sn_fx, sn_fy, seg_x, seg_y;
  logic [LEN_W-1:0] sn_len;
  logic [1:0] sn_state;
  logic [GRID_W-1:0] head_b, body_b, food_b, head_a, body_a, food_a, seg_hot, food_hot, col_hot;
  logic eol, snap_en, step, hit, food_hit, hd, bd, fd, visible, in_grid;
  logic [11:0] rgb_n;
  // decode of timing events, mask-build step and the colour of the current pixel
  always_comb begin
    eol = hcnt == 10'd799;
    snap_en = hcnt == 10'd0 && vcnt == 10'd480;
    k = hcnt - 10'd640;
    ki = k[KW-1:0];
    seg_x = sn_x[ki];
    seg_y = sn_y[ki];
    tgt = vcnt == 10'd524 ? 10'd0 : (vsub == 10'(TILE - 1) ? row + 10'd1 : row);
    step = hcnt >= 10'd640 && hcnt < 10'(640 + MAX_LEN);
    hit = step && k < 10'(sn_len) && 10'(seg_y) == tgt && tgt < 10'(GRID_H);
    food_hit = hcnt == 10'd640 && 10'(sn_fy) == tgt && tgt < 10'(GRID_H);
    for (int i = 0; i < GRID_W; i++) begin
      seg_hot[i] = seg_x == COORD_W'(i);
      food_hot[i] = sn_fx == COORD_W'(i);
    end
    col_hot = GRID_W'(1) << col;
    hd = |(head_a & col_hot);
    bd = |(body_a & col_hot);
    fd = |(food_a & col_hot);
    visible = hcnt < 10'd640 && vcnt < 10'd480;
    in_grid = hcnt < 10'(GRID_W * TILE) && vcnt < 10'(GRID_H * TILE);
    rgb_n = !visible ? 12'h000 :
            !in_grid ? BORDER_COLOR :
            sn_state == INITIAL ? INIT_COLOR :
            sn_state == BLANK ? 12'h000 :
            sn_state == RUNNING ? (hd ? HEAD_COLOR : bd ? BODY_COLOR : fd ? FOOD_COLOR : BG_COLOR) :
            (hd || bd) ? DIE_COLOR : fd ? FOOD_COLOR : BG_COLOR;
  end
  // pixel/line counters with tile and sub-tile position tracked alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
      col <= '0;
      hsub <= '0;
      row <= '0;
      vsub <= '0;
    end else begin
      hcnt <= eol ? 10'd0 : hcnt + 10'd1;
      col <= eol ? 10'd0 : (hsub == 10'(TILE - 1) ? col + 10'd1 : col);
      hsub <= (eol || hsub == 10'(TILE - 1)) ? 10'd0 : hsub + 10'd1;
      if (eol) begin
        vcnt <= vcnt == 10'd524 ? 10'd0 : vcnt + 10'd1;
        row <= vcnt == 10'd524 ? 10'd0 : (vsub == 10'(TILE - 1) ? row + 10'd1 : row);
        vsub <= (vcnt == 10'd524 || vsub == 10'(TILE - 1)) ? 10'd0 : vsub + 10'd1;
      end
    end
  end
  // once-per-frame snapshot of game state so a frame never mixes two game steps
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        sn_x[i] <= '0;
        sn_y[i] <= '0;
      end
      sn_fx <= '0;
      sn_fy <= '0;
      sn_len <= '0;
      sn_state <= INITIAL;
    end else if (snap_en) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        sn_x[i] <= snake_x_1dim[i*COORD_W +: COORD_W];
        sn_y[i] <= snake_y_1dim[i*COORD_W +: COORD_W];
      end
      sn_fx <= food_x;
      sn_fy <= food_y;
      sn_len <= snake_length > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : snake_length;
      sn_state <= game_state;
    end
  end
  // masks for the next line are built one segment per clock in h-blank, then swapped in at line end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_b <= '0;
      body_b <= '0;
      food_b <= '0;
      head_a <= '0;
      body_a <= '0;
      food_a <= '0;
    end else if (eol) begin
      head_a <= head_b;
      body_a <= body_b;
      food_a <= food_b;
      head_b <= '0;
      body_b <= '0;
      food_b <= '0;
    end else begin
      if (hit && k == 10'd0) head_b <= head_b | seg_hot;
      if (hit && k != 10'd0) body_b <= body_b | seg_hot;
      if (food_hit) food_b <= food_b | food_hot;
    end
  end
  // registered pixel and sync outputs, all aligned one cycle behind the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      {r, g, b} <= 12'h000;
      h_sync <= 1'b1;
      v_sync <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      {r, g, b} <= rgb_n;
      h_sync <= !(hcnt >= 10'd656 && hcnt < 10'd752);
      v_sync <= !(vcnt >= 10'd490 && vcnt < 10'd492);
      frame_tick <= snap_en;
    end
  end
endmodule

// File: tb/tb_snake_tile_renderer.sv
// tb_snake_tile_renderer: directed checks of timing, snapshot and tile rendering
module tb_snake_tile_renderer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] food_x = '0, food_y = '0;
  logic [319:0] sx = '0, sy = '0;
  logic [6:0] len = '0;
  logic [1:0] gs = 2'b10;
  logic [3:0] r, g, b;
  logic h_sync, v_sync, frame_tick;
  int vecs = 0, errs = 0;
  logic [9:0] w_v, w_row, w_sub;

  always #20 clk = ~clk;

  snake_tile_renderer dut (
    .clk(clk), .rst(rst), .food_x(food_x), .food_y(food_y),
    .snake_x_1dim(sx), .snake_y_1dim(sy), .snake_length(len), .game_state(gs),
    .r(r), .g(g), .b(b), .h_sync(h_sync), .v_sync(v_sync), .frame_tick(frame_tick)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic seg(input int k, input int x, input int y);
    sx[k*5 +: 5] = 5'(x);
    sy[k*5 +: 5] = 5'(y);
  endtask

  // jump the raster to the start of line v to avoid simulating whole frames
  task automatic warp(input int v);
    @(negedge clk);
    w_v = 10'(v);
    w_row = 10'(v / 20);
    w_sub = 10'(v % 20);
    force dut.hcnt = '0;
    force dut.col = '0;
    force dut.hsub = '0;
    force dut.vcnt = w_v;
    force dut.row = w_row;
    force dut.vsub = w_sub;
    #1;
    release dut.hcnt;
    release dut.col;
    release dut.hsub;
    release dut.vcnt;
    release dut.row;
    release dut.vsub;
  endtask

  task automatic pix(input int x, input int y, input logic [11:0] exp, input string tag);
    warp(y == 0 ? 524 : y - 1);
    repeat (801 + x) @(posedge clk);
    @(negedge clk);
    chk(tag, int'({r, g, b}), int'(exp));
  endtask

  task automatic snap();
    warp(479);
    repeat (800) @(posedge clk);
    @(negedge clk);
    chk("ft_pre", int'(frame_tick), 0);
    @(posedge clk);
    @(negedge clk);
    chk("ft_on", int'(frame_tick), 1);
    @(posedge clk);
    @(negedge clk);
    chk("ft_off", int'(frame_tick), 0);
  endtask

  task automatic reset_vals();
    chk("rst_rgb", int'({r, g, b}), 0);
    chk("rst_hs", int'(h_sync), 1);
    chk("rst_vs", int'(v_sync), 1);
    chk("rst_ft", int'(frame_tick), 0);
  endtask

  // release reset and time the first h_sync pulse; snapshot is back to INITIAL
  task automatic restart_check();
    int n, w, c;
    n = 0;
    rst = 1'b0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) chk("first_pixel", int'({r, g, b}), 'h00f);
      if (!h_sync) break;
    end
    chk("hs_fall", n, 657);
    w = 1;
    while (w < 2000) begin
      @(posedge clk);
      @(negedge clk);
      if (h_sync) break;
      w++;
    end
    chk("hs_low", w, 96);
    c = 1;
    while (c < 2000) begin
      @(posedge clk);
      @(negedge clk);
      if (!h_sync) break;
      c++;
    end
    chk("hs_period", w + c, 800);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_vals();
    restart_check();

    warp(489);
    @(posedge clk);
    @(negedge clk);
    chk("vs_489_first", int'(v_sync), 1);
    repeat (799) @(posedge clk);
    @(negedge clk);
    chk("vs_489_last", int'(v_sync), 1);
    @(posedge clk);
    @(negedge clk);
    chk("vs_490", int'(v_sync), 0);
    repeat (1599) @(posedge clk);
    @(negedge clk);
    chk("vs_491_last", int'(v_sync), 0);
    @(posedge clk);
    @(negedge clk);
    chk("vs_492", int'(v_sync), 1);

    gs = 2'b00;
    len = 7'd1;
    for (int k = 1; k < 64; k++) seg(k, 7, 7);
    seg(0, 3, 2);
    food_x = 5'd10;
    food_y = 5'd10;
    snap();
    seg(0, 20, 20);
    food_x = 5'd0;
    food_y = 5'd0;
    pix(60, 40, 12'hff0, "head_tl");
    pix(79, 59, 12'hff0, "head_br");
    pix(80, 40, 12'h000, "head_right");
    pix(59, 40, 12'h000, "head_left");
    pix(60, 39, 12'h000, "head_above");
    pix(60, 60, 12'h000, "head_below");
    pix(200, 200, 12'hfff, "food_tl");
    pix(219, 219, 12'hfff, "food_br");
    pix(220, 200, 12'h000, "food_right");
    pix(140, 140, 12'h000, "len_gate");
    pix(400, 400, 12'h000, "stale_input");

    len = 7'd2;
    seg(0, 5, 5);
    seg(1, 5, 5);
    food_x = 5'd5;
    food_y = 5'd5;
    snap();
    pix(100, 100, 12'hff0, "prio_head");
    pix(119, 119, 12'hff0, "prio_head_br");
    seg(0, 6, 5);
    pix(100, 100, 12'hff0, "coherent");
    snap();
    pix(100, 100, 12'hf00, "prio_body");
    pix(120, 100, 12'hff0, "moved_head");

    len = 7'd127;
    for (int k = 0; k < 64; k++) seg(k, k % 32, 10 + k / 32);
    snap();
    pix(0, 200, 12'hff0, "lim_head");
    pix(20, 200, 12'hf00, "lim_seg1");
    pix(620, 200, 12'hf00, "lim_seg31");
    pix(0, 220, 12'hf00, "lim_seg32");
    pix(639, 239, 12'hf00, "lim_seg63_edge");
    len = 7'd63;
    snap();
    pix(620, 220, 12'h000, "len63_no_last");
    pix(600, 220, 12'hf00, "len63_seg62");
    len = 7'd1;
    seg(0, 4, 30);
    snap();
    pix(80, 470, 12'h000, "y30_row23");
    pix(0, 200, 12'h000, "y30_old_gone");
    seg(0, 3, 2);
    len = 7'd0;
    snap();
    pix(60, 40, 12'h000, "len0");

    gs = 2'b01;
    len = 7'd2;
    seg(0, 1, 0);
    seg(1, 2, 0);
    food_x = 5'd3;
    food_y = 5'd0;
    snap();
    pix(20, 0, 12'h444, "die_head_l0");
    pix(40, 19, 12'h444, "die_body");
    pix(60, 0, 12'hfff, "die_food");
    pix(80, 0, 12'h000, "die_bg");

    gs = 2'b10;
    snap();
    pix(20, 20, 12'h00f, "init_a");
    pix(300, 300, 12'h00f, "init_b");
    pix(700, 20, 12'h000, "hblank");
    pix(20, 500, 12'h000, "vblank");

    gs = 2'b11;
    snap();
    pix(20, 0, 12'h000, "blank_a");
    pix(300, 300, 12'h000, "blank_b");
    warp(100);
    n = 0;
    repeat (800) begin
      @(posedge clk);
      @(negedge clk);
      if (!h_sync) n++;
    end
    chk("blank_hs_low", n, 96);

    warp(300);
    repeat (123) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_vals();
    restart_check();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
